// File: rtl/sys_block_encoder_if.sv
// Stream interface of the systematic block encoder: data words in, codewords out.
// Handshake: a transfer happens on a rising clock edge where valid and ready are
// both 1; the producer holds valid and its payload steady until that edge, and
// ready never depends combinationally on valid.
interface sys_block_encoder_if #(
   parameter int K     = 18,
   parameter int R     = 3,
   parameter int CNT_W = 16
) ();
   logic             in_valid;
   logic [K-1:0]     in_data;
   logic             in_ready;
   logic             enc_en;
   logic             out_valid;
   logic [K+R-1:0]   out_codeword;
   logic             out_ready;
   logic [CNT_W-1:0] cw_count;
   logic             overflow_err;

   // Source/sink side: drives the data word and the downstream ready.
   modport master (
      output in_valid, in_data, enc_en, out_ready,
      input  in_ready, out_valid, out_codeword, cw_count, overflow_err
   );

   // Encoder side.
   modport slave (
      input  in_valid, in_data, enc_en, out_ready,
      output in_ready, out_valid, out_codeword, cw_count, overflow_err
   );
endinterface

// File: rtl/sys_block_encoder.sv
// Systematic block encoder: codeword = {check[R-1:0], data[K-1:0]}, where each
// check bit is the XOR of the data bits selected by its PARITY_MASK slice.
// Codewords queue in a DEPTH-entry circular buffer so the source can keep
// streaming while the channel stage applies backpressure.
module sys_block_encoder #(
   parameter int               K           = 18,
   parameter int               R           = 3,
   parameter logic [R*K-1:0]   PARITY_MASK = 54'h40_0008_0001,
   parameter int               DEPTH       = 2,
   parameter int               CNT_W       = 16
) (
   input logic                clk,
   input logic                rst_n,
   sys_block_encoder_if.slave bus
);
   localparam int N     = K + R;
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int OCC_W = $clog2(DEPTH + 1);
   localparam logic [8:0] STALL_MAX = 9'd256;

   logic [N-1:0]     mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [OCC_W-1:0] occupancy;
   logic [OCC_W-1:0] occ_next;
   logic             in_ready_q;
   logic [CNT_W-1:0] cw_count_q;
   logic [8:0]       stall_cnt;
   logic             overflow_q;
   logic [R-1:0]     check;
   logic             push;
   logic             pop;
   logic             stall;

   // Pointers step 0..DEPTH-1 and wrap, so DEPTH need not be a power of two.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(DEPTH - 1)) return '0;
      return p + PTR_W'(1);
   endfunction

   assign push  = bus.in_valid && in_ready_q;
   assign pop   = (occupancy != '0) && bus.out_ready;
   assign stall = bus.in_valid && !in_ready_q;

   // Parity of the incoming word; all-zero check bits in pass-through mode.
   always_comb begin
      check = '0;
      if (bus.enc_en) begin
         for (int r = 0; r < R; r++) begin
            check[r] = ^(bus.in_data & PARITY_MASK[r*K +: K]);
         end
      end
   end

   // Occupancy after this edge; a simultaneous push and pop leaves it unchanged.
   always_comb begin
      occ_next = occupancy;
      if (push && !pop) begin
         occ_next = occupancy + OCC_W'(1);
      end else if (pop && !push) begin
         occ_next = occupancy - OCC_W'(1);
      end
   end

   // Buffer storage, pointers, occupancy and the registered ready.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         occupancy  <= '0;
         in_ready_q <= 1'b0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= {check, bus.in_data};
            wr_ptr      <= ptr_inc(wr_ptr);
         end
         if (pop) begin
            rd_ptr <= ptr_inc(rd_ptr);
         end
         occupancy  <= occ_next;
         in_ready_q <= (occ_next < OCC_W'(DEPTH));
      end
   end

   // Delivered-codeword counter; wraps silently.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cw_count_q <= '0;
      end else if (pop) begin
         cw_count_q <= cw_count_q + CNT_W'(1);
      end
   end

   // Consecutive-stall counter saturating at 256; reaching it latches the error.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt  <= '0;
         overflow_q <= 1'b0;
      end else if (stall) begin
         if (stall_cnt != STALL_MAX) begin
            stall_cnt <= stall_cnt + 9'd1;
         end
         if (stall_cnt == STALL_MAX - 9'd1) begin
            overflow_q <= 1'b1;
         end
      end else begin
         stall_cnt <= '0;
      end
   end

   assign bus.in_ready     = in_ready_q;
   assign bus.out_valid    = (occupancy != '0);
   assign bus.out_codeword = mem[rd_ptr];
   assign bus.cw_count     = cw_count_q;
   assign bus.overflow_err = overflow_q;
endmodule

// File: tb/tb_sys_block_encoder.sv
// Directed bench for sys_block_encoder: default-mask instance plus a second
// instance whose check bit 0 covers data bits 0..2.
module tb_sys_block_encoder;
   localparam int K     = 18;
   localparam int R     = 3;
   localparam int N     = K + R;
   localparam int CNT_W = 16;

   logic clk;
   logic rst_n;

   int n_compared   = 0;
   int n_mismatched = 0;

   logic [N-1:0] exp_q[$];

   sys_block_encoder_if #(.K(K), .R(R), .CNT_W(CNT_W)) bus  ();
   sys_block_encoder_if #(.K(K), .R(R), .CNT_W(CNT_W)) bus2 ();

   sys_block_encoder #(
      .K(K), .R(R), .PARITY_MASK(54'h40_0008_0001), .DEPTH(2), .CNT_W(CNT_W)
   ) u_dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   sys_block_encoder #(
      .K(K), .R(R), .PARITY_MASK(54'h40_0008_0007), .DEPTH(2), .CNT_W(CNT_W)
   ) u_mask (
      .clk(clk), .rst_n(rst_n), .bus(bus2)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_compared++;
      if (got !== exp) begin
         n_mismatched++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drain the buffer, checking heads against exp_q in order, bounded in cycles.
   task automatic drain_check(input string tag);
      logic push_now;
      bus.out_ready = 1'b1;
      for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
         if (bus.out_valid) check_val(tag, 32'(bus.out_codeword), 32'(exp_q.pop_front()));
         push_now = bus.in_valid && bus.in_ready;
         tick();
         if (push_now) bus.in_valid = 1'b0;
      end
      check_val({tag, "_left"}, exp_q.size(), 0);
      check_val({tag, "_empty"}, 32'(bus.out_valid), 0);
      bus.out_ready = 1'b0;
   endtask

   initial begin
      bus.in_valid   = 1'b0;
      bus.in_data    = '0;
      bus.enc_en     = 1'b1;
      bus.out_ready  = 1'b0;
      bus2.in_valid  = 1'b0;
      bus2.in_data   = '0;
      bus2.enc_en    = 1'b1;
      bus2.out_ready = 1'b1;
      rst_n          = 1'b0;

      // Reset state
      #2;
      check_val("rst_in_ready", 32'(bus.in_ready), 0);
      check_val("rst_out_valid", 32'(bus.out_valid), 0);
      check_val("rst_codeword", 32'(bus.out_codeword), 0);
      check_val("rst_cw_count", 32'(bus.cw_count), 0);
      check_val("rst_overflow", 32'(bus.overflow_err), 0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      check_val("post_rst_in_ready", 32'(bus.in_ready), 1);

      // 1: single word, parity on, immediate delivery
      bus.out_ready = 1'b1;
      bus.enc_en    = 1'b1;
      bus.in_data   = 18'h00005;
      bus.in_valid  = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      check_val("t1_valid", 32'(bus.out_valid), 1);
      check_val("t1_codeword", 32'(bus.out_codeword), 32'h140005);
      check_val("t1_count_before", 32'(bus.cw_count), 0);
      tick();
      check_val("t1_count_after", 32'(bus.cw_count), 1);
      check_val("t1_empty", 32'(bus.out_valid), 0);

      // 2: pass-through then encoded, same data
      bus.out_ready = 1'b0;
      bus.enc_en    = 1'b0;
      bus.in_data   = 18'h3FFFF;
      bus.in_valid  = 1'b1;
      tick();
      check_val("t2_passthru", 32'(bus.out_codeword), 32'h03FFFF);
      bus.enc_en = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      check_val("t2_full_ready", 32'(bus.in_ready), 0);
      check_val("t2_head_stable", 32'(bus.out_codeword), 32'h03FFFF);
      bus.out_ready = 1'b1;
      tick();
      check_val("t2_encoded", 32'(bus.out_codeword), 32'h1FFFFF);
      tick();
      bus.out_ready = 1'b0;
      check_val("t2_count", 32'(bus.cw_count), 3);

      // 3: backpressure, word 3 stalls; it is sent in pass-through mode
      bus.enc_en   = 1'b1;
      bus.in_data  = 18'h00001;
      bus.in_valid = 1'b1;
      tick();
      bus.in_data = 18'h00002;
      tick();
      bus.in_data = 18'h00003;
      bus.enc_en  = 1'b0;
      check_val("t3_stall_ready", 32'(bus.in_ready), 0);
      tick();
      tick();
      check_val("t3_occ", 32'(u_dut.occupancy), 2);
      check_val("t3_head_hold", 32'(bus.out_codeword), 32'h040001);
      exp_q = '{21'h040001, 21'h080002, 21'h000003};
      drain_check("t3_order");
      check_val("t3_count", 32'(bus.cw_count), 6);

      // 4: full buffer, one-cycle pop with push pending
      bus.enc_en   = 1'b1;
      bus.in_data  = 18'h00010;
      bus.in_valid = 1'b1;
      tick();
      bus.in_data = 18'h00020;
      tick();
      bus.in_data = 18'h00030;
      check_val("t4_occ_full", 32'(u_dut.occupancy), 2);
      check_val("t4_ready_full", 32'(bus.in_ready), 0);
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      check_val("t4_occ_after_pop", 32'(u_dut.occupancy), 1);
      check_val("t4_ready_rise", 32'(bus.in_ready), 1);
      tick();
      bus.in_valid = 1'b0;
      check_val("t4_occ_refill", 32'(u_dut.occupancy), 2);
      exp_q = '{21'h000020, 21'h000030};
      drain_check("t4_order");
      check_val("t4_count", 32'(bus.cw_count), 9);
      check_val("t4_no_overflow", 32'(bus.overflow_err), 0);

      // 5: overridden mask, check0 = d0^d1^d2
      bus2.in_data  = 18'h00003;
      bus2.in_valid = 1'b1;
      tick();
      bus2.in_valid = 1'b0;
      check_val("t5_check0_zero", 32'(bus2.out_codeword), 32'h080003);
      tick();
      bus2.in_data  = 18'h00007;
      bus2.in_valid = 1'b1;
      tick();
      bus2.in_valid = 1'b0;
      check_val("t5_check0_one", 32'(bus2.out_codeword), 32'h1C0007);
      tick();

      // 6: asynchronous reset with two entries buffered
      bus.in_data  = 18'h00040;
      bus.in_valid = 1'b1;
      tick();
      bus.in_data = 18'h00080;
      tick();
      bus.in_valid = 1'b0;
      check_val("t6_pre_occ", 32'(u_dut.occupancy), 2);
      #2;
      rst_n = 1'b0;
      #1;
      check_val("t6_rst_valid", 32'(bus.out_valid), 0);
      check_val("t6_rst_count", 32'(bus.cw_count), 0);
      check_val("t6_rst_codeword", 32'(bus.out_codeword), 0);
      check_val("t6_rst_ready", 32'(bus.in_ready), 0);
      tick();
      rst_n = 1'b1;
      tick();
      bus.in_valid = 1'b1;
      bus.in_data  = 18'h00001;
      tick();
      tick();
      check_val("t6_fill_ready", 32'(bus.in_ready), 0);
      for (int i = 0; i < 255; i++) tick();
      check_val("t6_ovf_255", 32'(bus.overflow_err), 0);
      tick();
      check_val("t6_ovf_256", 32'(bus.overflow_err), 1);
      bus.in_valid = 1'b0;
      tick();
      tick();
      check_val("t6_ovf_sticky", 32'(bus.overflow_err), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end
endmodule
